// File: rtl/hdmi_src_pkg.sv
// hdmi_src_pkg: shared timing header for the hdmi_src video source.
// Holds the default 64x64 raster timing, the derived line/frame totals,
// sync polarity constants, counter-width typed boundaries, the run-state
// enum and the stage-0 region decode struct.
package hdmi_src_pkg;

  localparam int H_ACTIVE = 64;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 8;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 64;
  localparam int V_BP     = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = V_BP + V_ACTIVE + V_FP + V_SYNC;

  // hs is asserted high; vs sits high outside a frame (sync lines and idle)
  localparam logic HS_ASSERT = 1'b1;
  localparam logic VS_BLANK  = 1'b1;

  localparam int CNT_W = 7;
  typedef logic [CNT_W-1:0] cnt_t;

  // Region boundaries pre-cast to the counter width so compares stay width-matched
  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_ACT_END  = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_ACT_BEG  = cnt_t'(V_BP);
  localparam cnt_t V_ACT_END  = cnt_t'(V_BP + V_ACTIVE);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_BP + V_ACTIVE + V_FP);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } region_t;

  function automatic logic in_range(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/hdmi_src_if.sv
// hdmi_src_if: bundles the pixel-memory read port and the HDMI-style
// output stream of hdmi_src.
//   pix_rd/pix_x/pix_y : read strobe and 6-bit column/row address (source -> memory)
//   pix_data           : 24-bit {R,G,B}, valid the cycle after pix_rd (memory -> source)
//   hdmi_vs/hs/de/data : video stream (source -> sink)
// master = the video source, slave = memory plus stream consumer.
interface hdmi_src_if;

  logic        pix_rd;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic [23:0] pix_data;
  logic        hdmi_vs;
  logic        hdmi_hs;
  logic        hdmi_de;
  logic [31:0] hdmi_data;

  modport master (
    output pix_rd, pix_x, pix_y,
    input  pix_data,
    output hdmi_vs, hdmi_hs, hdmi_de, hdmi_data
  );

  modport slave (
    input  pix_rd, pix_x, pix_y,
    output pix_data,
    input  hdmi_vs, hdmi_hs, hdmi_de, hdmi_data
  );

endinterface

// File: rtl/hdmi_timing_cnt.sv
// hdmi_timing_cnt: stage 0 of hdmi_src. Run/idle state machine, the h/v
// raster counters and the combinational region decodes.
//   hdmi_clk : pixel clock
//   rst      : synchronous active-high reset
//   en       : run request, only looked at in IDLE and on the last pixel of a frame
//   h, v     : raster position (both held at 0 while idle)
//   region   : active / hs / vs decodes of the current position
module hdmi_timing_cnt
  import hdmi_src_pkg::*;
(
  input  logic    hdmi_clk,
  input  logic    rst,
  input  logic    en,
  output cnt_t    h,
  output cnt_t    v,
  output region_t region
);

  run_state_t state;

  // Leaving IDLE keeps h=v=0, so the first RUN cycle is pixel (0,0).
  // Frames chain with no gap; en only matters on the very last pixel.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h <= '0;
          v <= '0;
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v <= '0;
              if (!en) state <= ST_IDLE;
            end else begin
              v <= v + 1'b1;
            end
          end else begin
            h <= h + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // vs stays at its blank level while idle so the stream looks frameless
  always_comb begin
    logic run;
    run           = (state == ST_RUN);
    region        = '0;
    region.active = run && (h < H_ACT_END) && in_range(v, V_ACT_BEG, V_ACT_END);
    region.hs     = (run && in_range(h, H_SYNC_BEG, H_SYNC_END)) ? HS_ASSERT : ~HS_ASSERT;
    region.vs     = (!run || (v >= V_SYNC_BEG)) ? VS_BLANK : ~VS_BLANK;
  end

endmodule

// File: rtl/hdmi_src.sv
// hdmi_src: 64x64 HDMI-style video source.
//   hdmi_clk  : pixel clock, the only clock
//   rst       : synchronous active-high reset
//   en        : run request, sampled at frame boundaries
//   frame_cnt : completed frames, bumps when hdmi_vs rises
//   bus       : hdmi_src_if master - pixel memory read port and video stream
// Stage 0 (hdmi_timing_cnt) produces position and decodes, stage 1 issues
// the memory read, stage 2 aligns de/hs/vs with the returning pixel.
module hdmi_src
  import hdmi_src_pkg::*;
(
  input  logic        hdmi_clk,
  input  logic        rst,
  input  logic        en,
  output logic [7:0]  frame_cnt,
  hdmi_src_if.master  bus
);

  cnt_t    h;
  cnt_t    v;
  region_t region;

  logic       rd_q;
  logic [5:0] x_q;
  logic [5:0] y_q;
  logic       hs_q;
  logic       vs_q;
  logic       de_qq;
  logic       hs_qq;
  logic       vs_qq;

  hdmi_timing_cnt u_cnt (
    .hdmi_clk (hdmi_clk),
    .rst      (rst),
    .en       (en),
    .h        (h),
    .v        (v),
    .region   (region)
  );

  // Stage 1: memory read request; the address holds between reads
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HS_ASSERT;
      vs_q <= VS_BLANK;
    end else begin
      rd_q <= region.active;
      hs_q <= region.hs;
      vs_q <= region.vs;
      if (region.active) begin
        x_q <= h[5:0];
        y_q <= 6'(v - V_ACT_BEG);
      end
    end
  end

  // Stage 2: de is the read strobe one cycle on, which is exactly when the
  // memory presents the pixel. frame_cnt watches for vs about to rise.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      de_qq     <= 1'b0;
      hs_qq     <= ~HS_ASSERT;
      vs_qq     <= VS_BLANK;
      frame_cnt <= '0;
    end else begin
      de_qq <= rd_q;
      hs_qq <= hs_q;
      vs_qq <= vs_q;
      if ((vs_q == VS_BLANK) && (vs_qq != VS_BLANK)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign bus.pix_rd    = rd_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.hdmi_de   = de_qq;
  assign bus.hdmi_hs   = hs_qq;
  assign bus.hdmi_vs   = vs_qq;
  // pix_data arrives straight from the memory's output register, so only gate it
  assign bus.hdmi_data = de_qq ? {8'h00, bus.pix_data} : 32'h0;

endmodule

// File: tb/tb_hdmi_src.sv
// tb_hdmi_src: self-checking bench for hdmi_src. A frame-position model
// (one integer position per cycle, -1 when idle) predicts every output each
// cycle; scenario tasks add spec-derived timing and count checks.
module tb_hdmi_src;

  localparam int HT    = 80;
  localparam int FRAME = 80 * 72;

  logic       hdmi_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic [7:0] frame_cnt;

  hdmi_src_if bus();

  hdmi_src dut (
    .hdmi_clk  (hdmi_clk),
    .rst       (rst),
    .en        (en),
    .frame_cnt (frame_cnt),
    .bus       (bus)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int checks = 0;
  int errors = 0;

  logic        use_rand = 1'b0;
  logic [23:0] rand_mem [4096];

  function automatic logic [23:0] mem_val(int x, int y);
    if (use_rand) return rand_mem[y*64 + x];
    return {8'(x), 8'(y), 8'(x ^ y)};
  endfunction

  // 1-cycle-latency pixel memory
  always @(posedge hdmi_clk)
    if (bus.pix_rd) bus.pix_data <= mem_val(int'(bus.pix_x), int'(bus.pix_y));

  // Reference: p is the position inside the frame, -1 means idle
  function automatic bit f_active(int p);
    if (p < 0) return 1'b0;
    return ((p % HT) < 64) && ((p / HT) >= 4) && ((p / HT) < 68);
  endfunction

  function automatic bit f_hs(int p);
    if (p < 0) return 1'b0;
    return ((p % HT) >= 68) && ((p % HT) < 72);
  endfunction

  function automatic bit f_vs(int p);
    if (p < 0) return 1'b1;
    return (p / HT) >= 70;
  endfunction

  function automatic int next_pos(int p, logic e);
    if (p < 0 || p == FRAME - 1) return e ? 0 : -1;
    return p + 1;
  endfunction

  int m_pos = -1, m_d1 = -1, m_d2 = -1, m_x = 0, m_y = 0, m_fc = 0;

  always @(posedge hdmi_clk) begin
    if (rst) begin
      m_pos <= -1; m_d1 <= -1; m_d2 <= -1;
      m_x <= 0; m_y <= 0; m_fc <= 0;
    end else begin
      m_pos <= next_pos(m_pos, en);
      m_d1  <= m_pos;
      m_d2  <= m_d1;
      if (f_active(m_pos)) begin
        m_x <= m_pos % HT;
        m_y <= m_pos / HT - 4;
      end
      if (f_vs(m_d1) && !f_vs(m_d2)) m_fc <= (m_fc + 1) % 256;
    end
  end

  logic  mon_on = 1'b0;
  int    trace_bad = 0;
  string first_msg = "";

  // Per-cycle comparison of every output with the model
  always @(negedge hdmi_clk) begin : monitor
    logic        e_rd, e_de, e_hs, e_vs;
    logic [31:0] e_data;
    if (mon_on) begin
      e_rd   = f_active(m_d1);
      e_de   = f_active(m_d2);
      e_hs   = f_hs(m_d2);
      e_vs   = f_vs(m_d2);
      e_data = e_de ? {8'h00, mem_val(m_d2 % HT, m_d2 / HT - 4)} : 32'h0;
      if (bus.pix_rd !== e_rd || bus.pix_x !== 6'(m_x) || bus.pix_y !== 6'(m_y) ||
          bus.hdmi_de !== e_de || bus.hdmi_hs !== e_hs || bus.hdmi_vs !== e_vs ||
          bus.hdmi_data !== e_data || frame_cnt !== 8'(m_fc)) begin
        if (trace_bad == 0)
          first_msg = $sformatf("t=%0t rd=%b/%b x=%0d/%0d y=%0d/%0d de=%b/%b hs=%b/%b vs=%b/%b data=%h/%h fc=%0d/%0d",
            $time, bus.pix_rd, e_rd, bus.pix_x, m_x, bus.pix_y, m_y, bus.hdmi_de, e_de,
            bus.hdmi_hs, e_hs, bus.hdmi_vs, e_vs, bus.hdmi_data, e_data, frame_cnt, m_fc);
        trace_bad <= trace_bad + 1;
      end
    end
  end

  task automatic tick;
    @(negedge hdmi_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b1;
    repeat (4) tick();
    mon_on = 1'b1;
    checks++; if (bus.pix_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_rd: got %b want 0", bus.pix_rd); end
    checks++; if (bus.pix_x !== 6'd0) begin errors++; $display("[TB] FAIL reset_pix_x: got %0d want 0", bus.pix_x); end
    checks++; if (bus.pix_y !== 6'd0) begin errors++; $display("[TB] FAIL reset_pix_y: got %0d want 0", bus.pix_y); end
    checks++; if (bus.hdmi_de !== 1'b0) begin errors++; $display("[TB] FAIL reset_de: got %b want 0", bus.hdmi_de); end
    checks++; if (bus.hdmi_hs !== 1'b0) begin errors++; $display("[TB] FAIL reset_hs: got %b want 0", bus.hdmi_hs); end
    checks++; if (bus.hdmi_vs !== 1'b1) begin errors++; $display("[TB] FAIL reset_vs: got %b want 1", bus.hdmi_vs); end
    checks++; if (bus.hdmi_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", bus.hdmi_data); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (bus.hdmi_vs !== 1'b1 || bus.pix_rd !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_run: got vs=%b rd=%b want vs=1 rd=0", bus.hdmi_vs, bus.pix_rd); end
  endtask

  task automatic test_single_frame;
    int de_cnt = 0, first_rd = -1, first_de = -1, last_de = -1, vs_fall = -1, vs_rise = -1, bad0;
    logic prev_vs = 1'b1;
    logic [31:0] d322 = 32'hDEAD_BEEF, d5425 = 32'hDEAD_BEEF;
    do_reset();
    use_rand = 1'b0;
    bad0 = trace_bad;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 0; t < 5800; t++) begin
      if (bus.pix_rd && first_rd < 0) first_rd = t;
      if (bus.hdmi_de) begin
        de_cnt++;
        if (first_de < 0) first_de = t;
        last_de = t;
      end
      if (t == 322) d322 = bus.hdmi_data;
      if (t == 5425) d5425 = bus.hdmi_data;
      if (prev_vs && !bus.hdmi_vs && vs_fall < 0) vs_fall = t;
      if (!prev_vs && bus.hdmi_vs && vs_rise < 0) vs_rise = t;
      prev_vs = bus.hdmi_vs;
      tick();
    end
    checks++; if (de_cnt !== 4096) begin errors++; $display("[TB] FAIL single_de_count: got %0d want 4096", de_cnt); end
    checks++; if (first_rd !== 321) begin errors++; $display("[TB] FAIL single_first_rd: got t=%0d want 321", first_rd); end
    checks++; if (first_de !== 322) begin errors++; $display("[TB] FAIL single_first_de: got t=%0d want 322", first_de); end
    checks++; if (last_de !== 5425) begin errors++; $display("[TB] FAIL single_last_de: got t=%0d want 5425", last_de); end
    checks++; if (vs_fall !== 2) begin errors++; $display("[TB] FAIL single_vs_fall: got t=%0d want 2", vs_fall); end
    checks++; if (vs_rise !== 5602) begin errors++; $display("[TB] FAIL single_vs_rise: got t=%0d want 5602", vs_rise); end
    checks++; if (d322 !== 32'h0000_0000) begin errors++; $display("[TB] FAIL single_data_first: got %h want 00000000", d322); end
    checks++; if (d5425 !== 32'h003F_3F00) begin errors++; $display("[TB] FAIL single_data_last: got %h want 003f3f00", d5425); end
    checks++; if (bus.hdmi_vs !== 1'b1 || bus.pix_rd !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_after: got vs=%b rd=%b want vs=1 rd=0", bus.hdmi_vs, bus.pix_rd); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (trace_bad - bad0 !== 0) begin errors++; $display("[TB] FAIL single_trace: got %0d bad cycles want 0 (%s)", trace_bad - bad0, first_msg); end
  endtask

  task automatic test_en_drop;
    int de_cnt = 0, rd_cnt = 0, late_rd = 0, bad0;
    do_reset();
    bad0 = trace_bad;
    en = 1'b1;
    tick();
    for (int t = 0; t < FRAME + 300; t++) begin
      if (t == 1000) en = 1'b0;
      if (bus.hdmi_de) de_cnt++;
      if (bus.pix_rd) rd_cnt++;
      if (bus.pix_rd && t >= FRAME) late_rd++;
      tick();
    end
    checks++; if (de_cnt !== 4096) begin errors++; $display("[TB] FAIL drop_de_count: got %0d want 4096", de_cnt); end
    checks++; if (rd_cnt !== 4096) begin errors++; $display("[TB] FAIL drop_rd_count: got %0d want 4096", rd_cnt); end
    checks++; if (late_rd !== 0) begin errors++; $display("[TB] FAIL drop_late_rd: got %0d want 0", late_rd); end
    checks++; if (frame_cnt !== 8'd1 || bus.hdmi_vs !== 1'b1) begin errors++; $display("[TB] FAIL drop_idle: got fc=%0d vs=%b want fc=1 vs=1", frame_cnt, bus.hdmi_vs); end
    checks++; if (trace_bad - bad0 !== 0) begin errors++; $display("[TB] FAIL drop_trace: got %0d bad cycles want 0 (%s)", trace_bad - bad0, first_msg); end
  endtask

  task automatic test_back_to_back;
    int rise_t[3] = '{-1, -1, -1};
    int fall_t[3] = '{-1, -1, -1};
    int nr = 0, nf = 0, de_cnt = 0, bad0;
    logic prev_vs = 1'b1;
    do_reset();
    for (int i = 0; i < 4096; i++) rand_mem[i] = 24'($urandom);
    use_rand = 1'b1;
    bad0 = trace_bad;
    en = 1'b1;
    tick();
    for (int t = 0; t < 3*FRAME + 40; t++) begin
      if (t < 2*FRAME) en = ((t % FRAME) >= 5700) ? 1'b1 : 1'($urandom_range(0, 1));
      else en = 1'b0;
      if (bus.hdmi_de) de_cnt++;
      if (!prev_vs && bus.hdmi_vs) begin if (nr < 3) rise_t[nr] = t; nr++; end
      if (prev_vs && !bus.hdmi_vs) begin if (nf < 3) fall_t[nf] = t; nf++; end
      prev_vs = bus.hdmi_vs;
      tick();
    end
    checks++; if (nr !== 3) begin errors++; $display("[TB] FAIL b2b_rise_count: got %0d want 3", nr); end
    checks++; if (rise_t[0] !== 5602) begin errors++; $display("[TB] FAIL b2b_first_rise: got t=%0d want 5602", rise_t[0]); end
    checks++; if (rise_t[1] - rise_t[0] !== FRAME || rise_t[2] - rise_t[1] !== FRAME) begin errors++; $display("[TB] FAIL b2b_period: got %0d,%0d want 5760", rise_t[1] - rise_t[0], rise_t[2] - rise_t[1]); end
    checks++; if (fall_t[1] - rise_t[0] !== 160 || fall_t[2] - rise_t[1] !== 160) begin errors++; $display("[TB] FAIL b2b_vs_width: got %0d,%0d want 160", fall_t[1] - rise_t[0], fall_t[2] - rise_t[1]); end
    checks++; if (de_cnt !== 3*4096) begin errors++; $display("[TB] FAIL b2b_de_count: got %0d want 12288", de_cnt); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL b2b_frame_cnt: got %0d want 3", frame_cnt); end
    checks++; if (trace_bad - bad0 !== 0) begin errors++; $display("[TB] FAIL b2b_trace: got %0d bad cycles want 0 (%s)", trace_bad - bad0, first_msg); end
    use_rand = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int t_rst, de_cnt = 0, first_de = -1, bad0;
    logic de_before;
    t_rst = 322 + HT * int'($urandom_range(1, 60)) + int'($urandom_range(0, 50));
    bad0 = trace_bad;
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL mid_pre_frame_cnt: got %0d want 3", frame_cnt); end
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 0; t < t_rst; t++) tick();
    de_before = bus.hdmi_de;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (de_before !== 1'b1) begin errors++; $display("[TB] FAIL mid_de_before: got %b want 1 at t=%0d", de_before, t_rst); end
    checks++; if (bus.hdmi_de !== 1'b0 || bus.hdmi_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_de_after: got de=%b data=%h want 0", bus.hdmi_de, bus.hdmi_data); end
    checks++; if (bus.hdmi_vs !== 1'b1 || bus.hdmi_hs !== 1'b0) begin errors++; $display("[TB] FAIL mid_sync_after: got vs=%b hs=%b want vs=1 hs=0", bus.hdmi_vs, bus.hdmi_hs); end
    checks++; if (bus.pix_rd !== 1'b0 || bus.pix_x !== 6'd0 || bus.pix_y !== 6'd0) begin errors++; $display("[TB] FAIL mid_rd_after: got rd=%b x=%0d y=%0d want 0", bus.pix_rd, bus.pix_x, bus.pix_y); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_frame_cnt: got %0d want 0", frame_cnt); end
    repeat (3) tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 0; t < 5800; t++) begin
      if (bus.hdmi_de) begin
        de_cnt++;
        if (first_de < 0) first_de = t;
      end
      tick();
    end
    checks++; if (first_de !== 322) begin errors++; $display("[TB] FAIL mid_restart_first_de: got t=%0d want 322", first_de); end
    checks++; if (de_cnt !== 4096 || frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_restart_frame: got de=%0d fc=%0d want 4096/1", de_cnt, frame_cnt); end
    checks++; if (trace_bad - bad0 !== 0) begin errors++; $display("[TB] FAIL mid_trace: got %0d bad cycles want 0 (%s)", trace_bad - bad0, first_msg); end
  endtask

  initial begin
    $display("[TB] hdmi_src bench start");
    test_reset();
    test_single_frame();
    test_en_drop();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_src.md
# hdmi_src

Synthesizable video source that generates 64×64 frames on the same HDMI-style stream (`hdmi_clk`, `hdmi_vs`, `hdmi_de`, `hdmi_data`) that the simulation PPM logger consumes.
- Produces horizontal and vertical timing and fetches pixels from an external 1-cycle-latency memory port.
- Drives aligned `de`, `hs`, `vs` and data.
- Feeds the vision pipeline in hardware and, in simulation, drives the logger directly for loopback tests.

## Interface
- `H_ACTIVE`, 64, active pixels per line
- `H_FP`, 4, horizontal front porch, in clocks
- `H_SYNC`, 4, hsync width, in clocks
- `H_BP`, 8, horizontal back porch, in clocks (H_TOTAL = 80)
- `V_ACTIVE`, 64, active lines per frame
- `V_BP`, 4, blank lines before the active region
- `V_FP`, 2, blank lines after the active region
- `V_SYNC`, 2, lines with `hdmi_vs` high (V_TOTAL = 72)
- `hdmi_clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run request; sampled at frame boundaries only
- `pix_rd`  out  1  pixel read strobe to memory
- `pix_x`  out  6  column address, valid with `pix_rd`
- `pix_y`  out  6  row address, valid with `pix_rd`
- `pix_data`  in  24  RGB {R,G,B}; valid the cycle after `pix_rd`
- `hdmi_vs`  out  1  active-low frame strobe: low for the whole frame, high during the V_SYNC lines and when idle
- `hdmi_hs`  out  1  active-high hsync
- `hdmi_de`  out  1  data enable
- `hdmi_data`  out  32  {8'h00, R, G, B} when `hdmi_de`=1, else 0
- `frame_cnt`  out  8  completed frames; wraps 255→0

## Operation
- State machine:
  - IDLE → RUN when `en`=1; counters start at h=0, v=0 on the next cycle.
  - RUN → IDLE only at h=H_TOTAL-1, v=V_TOTAL-1 with `en`=0.
  - Otherwise frames run back-to-back with no gap.
- Counters (stage 0):
  - h: 0..H_TOTAL-1.
  - v: 0..V_TOTAL-1; increments when h wraps and wraps to 0 after V_TOTAL-1.
  - Both are held at 0 in IDLE.
- Horizontal order: active [0,H_ACTIVE), FP, SYNC (hs=1), BP.
- Vertical order: BP lines [0,V_BP), active [V_BP,V_BP+V_ACTIVE), FP, then SYNC lines (vs=1).
- Active region means h<H_ACTIVE and v in the vertical active range.
- Stage 1 (registered): `pix_rd` = active; `pix_x` = h; `pix_y` = v-V_BP.
  - Address outputs hold their last value when `pix_rd`=0.
- Stage 2 (registered): `hdmi_de`, `hdmi_hs`, `hdmi_vs` are the stage-0 decodes delayed 2 cycles.
  - `hdmi_data` = {8'h00,`pix_data`} gated by de.
- `frame_cnt` increments on the cycle `hdmi_vs` rises, i.e. at the end of every frame.
- Reset, including mid-frame, takes effect on the next cycle:
  - state IDLE, counters 0;
  - `pix_rd`=0, `pix_x`=0, `pix_y`=0;
  - `hdmi_de`=0, `hdmi_hs`=0, `hdmi_vs`=1, `hdmi_data`=0;
  - `frame_cnt`=0.
- `en` changes mid-frame are ignored until the frame boundary.

## Timing
- Counter → outputs latency: 2 cycles. `pix_rd` → `pix_data` latency: exactly 1 cycle. The memory must not stall.
- `hdmi_de` and `hdmi_vs` falling are never simultaneous: the first de comes V_BP lines after vs falls.
- With defaults:
  - frame period 5760 cycles;
  - vs high for 160 cycles per frame;
  - 4096 de cycles per frame;
  - hs high 4 cycles per line, starting at h=68 (output cycle h+2).
- Taking the cycle after IDLE→RUN as t=0:
  - vs falls at t=2;
  - first `pix_rd` at t=321, first de at t=322;
  - last de at t=322+63·80+63 = 5425;
  - vs rises at t=5602.

## Structure
- A shared `hdmi_timing` header holds:
  - default timing constants and derived H_TOTAL/V_TOTAL;
  - sync polarity constants.
- Sub-module `hdmi_timing_cnt` holds the h/v counters, the run state machine, and the region decodes.
- `hdmi_src` adds the fetch stage and the output stage.

## Test plan
- Reset check: hold `rst` with `en`=1 → all outputs at their reset values, `frame_cnt`=0.
- Single frame:
  - stimulus: memory model returns {x,y,x^y}, `en` pulsed for one cycle in IDLE;
  - required: exactly 4096 de cycles; first `hdmi_data`=32'h0000_0000 at t=322; pixel (63,63) gives 32'h003F_3F00 at t=5425; then IDLE with `hdmi_vs`=1 and `frame_cnt`=1.
- Back-to-back: `en` held high for 3 frames → vs high exactly 160 cycles each time, period 5760, `frame_cnt`=3.
- `en` dropped mid-frame at t=1000 → frame completes with 4096 de, then IDLE, no further `pix_rd`.
- Reset asserted at t=2000 mid-line → next cycle de=0, vs=1, `pix_rd`=0; restart matches the single-frame timing.
- Loopback: drive the PPM logger for 2 frames → two 64×64 files whose pixels equal the memory contents.
